ext_mem_responder: RTL and testbench
====================================

// Module: ext_mem_responder
// PURPOSE
//  Memory-side responder for the SAP-3 core's external memory port. Decodes bus, mem_mar_we and
//  mem_ram_we, holds the MAR, stores bytes in an on-chip RAM and returns mem_out.
//  Adds a byte-stream program loader. The loader fills RAM while it holds the core in reset (cpu_rst).
//  Sits beside the core in the chip top, on the core's CLK.
// PARAMETERS
//  ADDR_W   8   RAM address width; depth = 2**ADDR_W bytes
// PORTS
//  CLK          in   1   system clock; same clock that feeds the core's clock block
//  rst_n        in   1   asynchronous reset, active low
//  bus          in   16  core bus; bus[15:0] is the address source, bus[7:0] the write data
//  mem_mar_we   in   1   latch MAR from bus on the next CLK rising edge
//  mem_ram_we   in   1   write bus[7:0] to RAM[MAR] on the next CLK rising edge
//  mem_out      out  8   read data = RAM[MAR]; combinational from MAR and RAM
//  ld_start     in   1   pulse: begin a program load from address 0
//  ld_valid     in   1   ld_data is valid
//  ld_last      in   1   qualifies ld_valid; marks the final byte of the load
//  ld_data      in   8   load byte
//  ld_ready     out  1   loader accepts a byte this cycle
//  cpu_rst      out  1   active-high reset for the core (drives the core's rst)
//  oob_err      out  1   sticky: out-of-range access or load overflow occurred
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, MAR=0, ld_ptr=0, cpu_rst=1, ld_ready=0, oob_err=0.
//    RAM contents are not cleared. mem_out then shows RAM[0].
//  - FSM states IDLE, LOAD, RUN; transitions occur on the CLK rising edge.
//    IDLE: cpu_rst=1. If ld_start=1, go to LOAD and set ld_ptr=0.
//    LOAD: cpu_rst=1, ld_ready=1. Each cycle with ld_valid=1 writes RAM[ld_ptr]=ld_data.
//      If ld_ptr = 2**ADDR_W-1 before the write, ld_ptr saturates there.
//      While ld_ptr is saturated, further bytes are dropped and oob_err is set. Otherwise ld_ptr increments.
//      ld_valid&ld_last: that byte is written, then go to RUN. cpu_rst reads 0 from the next cycle.
//      ld_start=1 while in LOAD sets ld_ptr=0 (restart). The current byte, if any, is still written at the old ld_ptr.
//    RUN: cpu_rst=0, ld_ready=0. Core-port handling is enabled only in this state.
//      ld_start=1 goes to LOAD with ld_ptr=0 and cpu_rst=1 from the next cycle.
//  - While the state is not RUN, mem_mar_we and mem_ram_we are ignored and MAR holds.
//  - MAR is 16 bits. When mem_mar_we=1, MAR takes bus[15:0] at the edge.
//    mem_out follows the new MAR in the same cycle the register updates; there is no added latency.
//  - In range: MAR[15:ADDR_W]==0. mem_out = RAM[MAR[ADDR_W-1:0]].
//  - Out of range:
//    mem_out = 8'h00.
//    mem_ram_we=1 is ignored and sets oob_err.
//    mem_mar_we loading an out-of-range address alone does not set oob_err.
//  - mem_ram_we=1: RAM[MAR] takes bus[7:0] at the edge. mem_out reflects the write in the cycle after.
//  - mem_mar_we and mem_ram_we both 1: the write uses the old MAR and MAR updates at the same edge.
//  - Strobes held high (core halted): the repeated MAR loads or writes are idempotent and need no special handling.
//  - oob_err clears only on reset.
//  - Reset mid-load: return to IDLE and hold the core in reset. Bytes already written remain.
// TESTING
//  1. Reset, then ld_start. Stream 8'h3E, 8'h05, 8'h76 with ld_last on 8'h76.
//     -> RAM[0..2] = 3E,05,76. cpu_rst falls exactly 1 cycle after the last byte is accepted.
//  2. RUN: mar_we with bus=16'h0001. -> mem_out=8'h05 after the edge.
//     Then ram_we with bus=16'h00AA. -> mem_out=8'hAA on the following cycle.
//  3. RUN: mar_we with bus=16'h1234 (ADDR_W=8). -> mem_out=8'h00 and oob_err stays 0.
//     Then ram_we. -> oob_err=1 and RAM unchanged.
//  4. Load 2**ADDR_W+2 bytes. -> the last RAM byte holds byte 255, the 2 extra bytes are dropped, oob_err=1.
//  5. Pull rst_n low mid-load at ld_ptr=4. -> IDLE, cpu_rst=1, ld_ready=0, RAM[0..3] kept.
//     New load proceeds from address 0.
//  6. Same-edge mar_we+ram_we with MAR=2 and bus=16'h0007. -> RAM[2]=8'h07, then MAR=7.

Source files
------------

// File: rtl/ext_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : ext_mem_responder
// Brief  : External memory responder for the SAP-3 core with a byte-stream
//          program loader that holds the core in reset while filling RAM.
// Rev    : 1.0
// ============================================================================
module ext_mem_responder #(
    parameter int ADDR_W = 8
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [15:0] bus,
    input  logic        mem_mar_we,
    input  logic        mem_ram_we,
    output logic [7:0]  mem_out,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic        ld_last,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        cpu_rst,
    output logic        oob_err
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        mar_q, mar_d;
    logic [ADDR_W-1:0]  ld_ptr_q, ld_ptr_d;
    logic               ld_sat_q, ld_sat_d;
    logic               oob_err_q, oob_err_d;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [7:0]         ram_wdata;
    logic [7:0]         ram [DEPTH];
    logic               mar_in_range;

    generate
        if (ADDR_W < 16) begin : g_range_check
            assign mar_in_range = (mar_q[15:ADDR_W] == '0);
        end else begin : g_range_full
            assign mar_in_range = 1'b1;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        mar_d     = mar_q;
        ld_ptr_d  = ld_ptr_q;
        ld_sat_d  = ld_sat_q;
        oob_err_d = oob_err_q;
        ram_we    = 1'b0;
        ram_waddr = ld_ptr_q;
        ram_wdata = ld_data;

        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d  = ST_LOAD;
                    ld_ptr_d = '0;
                    ld_sat_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    // The top byte is written once; the pointer then parks and later bytes are dropped.
                    if (ld_sat_q) begin
                        oob_err_d = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                        if (ld_ptr_q == PTR_MAX) begin
                            ld_sat_d = 1'b1;
                        end else begin
                            ld_ptr_d = ld_ptr_q + 1'b1;
                        end
                    end
                    if (ld_last) begin
                        state_d = ST_RUN;
                    end
                end
                // A restart wins over ld_last; the current byte still lands at the old pointer.
                if (ld_start) begin
                    state_d  = ST_LOAD;
                    ld_ptr_d = '0;
                    ld_sat_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (mem_ram_we) begin
                    if (mar_in_range) begin
                        ram_we    = 1'b1;
                        ram_waddr = mar_q[ADDR_W-1:0];
                        ram_wdata = bus[7:0];
                    end else begin
                        oob_err_d = 1'b1;
                    end
                end
                if (mem_mar_we) begin
                    mar_d = bus;
                end
                if (ld_start) begin
                    state_d  = ST_LOAD;
                    ld_ptr_d = '0;
                    ld_sat_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mar_q     <= '0;
            ld_ptr_q  <= '0;
            ld_sat_q  <= 1'b0;
            oob_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_d;
            ld_ptr_q  <= ld_ptr_d;
            ld_sat_q  <= ld_sat_d;
            oob_err_q <= oob_err_d;
        end
    end

    // RAM contents deliberately survive reset so a loaded program is kept.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    assign mem_out  = mar_in_range ? ram[mar_q[ADDR_W-1:0]] : 8'h00;
    assign ld_ready = (state_q == ST_LOAD);
    assign cpu_rst  = (state_q != ST_RUN);
    assign oob_err  = oob_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_ext_mem_responder
// Brief  : Self-checking bench for ext_mem_responder with a reference model.
// Rev    : 1.0
// ============================================================================
module tb_ext_mem_responder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [15:0] bus;
    logic        mem_mar_we;
    logic        mem_ram_we;
    logic [7:0]  mem_out;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_last;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        cpu_rst;
    logic        oob_err;

    always #5 CLK = ~CLK;

    ext_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .bus        (bus),
        .mem_mar_we (mem_mar_we),
        .mem_ram_we (mem_ram_we),
        .mem_out    (mem_out),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_last    (ld_last),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .cpu_rst    (cpu_rst),
        .oob_err    (oob_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode flags, byte counter for the loader, integer MAR.
    bit         m_loading;
    bit         m_running;
    bit         m_oob;
    int         m_ptr;
    int         m_mar;
    logic [7:0] m_ram   [DEPTH];
    bit         m_known [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_running = 1'b0;
        m_oob     = 1'b0;
        m_ptr     = 0;
        m_mar     = 0;
    endtask

    task automatic model_edge();
        if (m_loading) begin
            if (ld_valid) begin
                if (m_ptr < DEPTH) begin
                    m_ram[m_ptr]   = ld_data;
                    m_known[m_ptr] = 1'b1;
                    m_ptr++;
                end else begin
                    m_oob = 1'b1;
                end
            end
            if (ld_start) begin
                m_ptr = 0;
            end else if (ld_valid && ld_last) begin
                m_loading = 1'b0;
                m_running = 1'b1;
            end
        end else if (m_running) begin
            if (mem_ram_we) begin
                if (m_mar < DEPTH) begin
                    m_ram[m_mar]   = bus[7:0];
                    m_known[m_mar] = 1'b1;
                end else begin
                    m_oob = 1'b1;
                end
            end
            if (mem_mar_we) m_mar = int'(bus);
            if (ld_start) begin
                m_running = 1'b0;
                m_loading = 1'b1;
                m_ptr     = 0;
            end
        end else if (ld_start) begin
            m_loading = 1'b1;
            m_ptr     = 0;
        end
    endtask

    task automatic check_outputs();
        chk("cpu_rst", 32'(cpu_rst), 32'(!m_running));
        chk("ld_ready", 32'(ld_ready), 32'(m_loading));
        chk("oob_err", 32'(oob_err), 32'(m_oob));
        if (m_mar >= DEPTH) chk("mem_out_oob", 32'(mem_out), 32'h0);
        else if (m_known[m_mar]) chk("mem_out", 32'(mem_out), 32'(m_ram[m_mar]));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic clear_in();
        bus        = '0;
        mem_mar_we = 1'b0;
        mem_ram_we = 1'b0;
        ld_start   = 1'b0;
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        ld_data    = '0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
        chk("rst_ld_ready", 32'(ld_ready), 32'h0);
        chk("rst_oob_err", 32'(oob_err), 32'h0);
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d, input bit last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic set_mar(input logic [15:0] a);
        mem_mar_we = 1'b1;
        bus        = a;
        tick();
        mem_mar_we = 1'b0;
    endtask

    task automatic wr(input logic [15:0] d);
        mem_ram_we = 1'b1;
        bus        = d;
        tick();
        mem_ram_we = 1'b0;
    endtask

    function automatic logic [7:0] fill_byte(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i < DEPTH) ? (b ^ 8'h5A) : 8'hFF;
    endfunction

    initial begin
        rst_n = 1'b0;
        clear_in();
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        model_reset();
        #12;
        do_reset();

        // Basic load of a three-byte program.
        start_load();
        load_byte(8'h3E, 1'b0);
        load_byte(8'h05, 1'b0);
        chk("t1_cpu_rst_held", 32'(cpu_rst), 32'h1);
        load_byte(8'h76, 1'b1);
        chk("t1_cpu_rst_fall", 32'(cpu_rst), 32'h0);
        set_mar(16'h0000);
        chk("t1_ram0", 32'(mem_out), 32'h3E);
        set_mar(16'h0002);
        chk("t1_ram2", 32'(mem_out), 32'h76);

        // Core read then write.
        set_mar(16'h0001);
        chk("t2_read1", 32'(mem_out), 32'h05);
        wr(16'h00AA);
        chk("t2_write1", 32'(mem_out), 32'hAA);

        // Out-of-range access.
        set_mar(16'h1234);
        chk("t3_oob_read", 32'(mem_out), 32'h00);
        chk("t3_oob_noerr", 32'(oob_err), 32'h0);
        wr(16'h00BB);
        chk("t3_oob_err", 32'(oob_err), 32'h1);
        set_mar(16'h0001);
        chk("t3_ram_kept", 32'(mem_out), 32'hAA);

        // Overflowing load.
        do_reset();
        start_load();
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_byte(fill_byte(i), i == DEPTH + 1);
            if (i == DEPTH - 1) chk("t4_no_err_at_top", 32'(oob_err), 32'h0);
        end
        chk("t4_oob_err", 32'(oob_err), 32'h1);
        chk("t4_running", 32'(cpu_rst), 32'h0);
        set_mar(16'h00FF);
        chk("t4_top_byte", 32'(mem_out), 32'hA5);
        set_mar(16'h0000);
        chk("t4_no_wrap", 32'(mem_out), 32'h5A);

        // Same-edge MAR load and write.
        set_mar(16'h0002);
        mem_mar_we = 1'b1;
        mem_ram_we = 1'b1;
        bus        = 16'h0007;
        tick();
        clear_in();
        chk("t6_new_mar", 32'(mem_out), 32'h5D);
        set_mar(16'h0002);
        chk("t6_old_mar_written", 32'(mem_out), 32'h07);

        // Reset in the middle of a load.
        start_load();
        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        load_byte(8'h33, 1'b0);
        load_byte(8'h44, 1'b0);
        do_reset();
        start_load();
        load_byte(8'h99, 1'b0);
        load_byte(8'h88, 1'b1);
        set_mar(16'h0000);
        chk("t5_new0", 32'(mem_out), 32'h99);
        set_mar(16'h0001);
        chk("t5_new1", 32'(mem_out), 32'h88);
        set_mar(16'h0002);
        chk("t5_kept2", 32'(mem_out), 32'h33);
        set_mar(16'h0003);
        chk("t5_kept3", 32'(mem_out), 32'h44);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(499) == 0) begin
                clear_in();
                do_reset();
            end
            ld_start   = ($urandom_range(49) == 0);
            ld_valid   = $urandom_range(1) == 1;
            ld_last    = ($urandom_range(15) == 0);
            ld_data    = 8'($urandom);
            mem_mar_we = ($urandom_range(2) == 0);
            mem_ram_we = ($urandom_range(3) == 0);
            bus        = ($urandom_range(3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
            tick();
        end
        clear_in();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
